// File: rtl/jpeg_idct_pingpong_ram.sv
// Ping-pong block store between IDCT stages; define JPEG_IDCT_RAM_TRANSPOSE_EN to read with row/col swapped address.
// Read latency 1 cycle; writes stall via wr_ready_o while both banks are committed, reads wait on rd_valid_o.
module jpeg_idct_pingpong_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_last_i,
  output logic              wr_ready_o,
  output logic              rd_valid_o,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_last_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_data_valid_o,
  output logic [1:0]        level_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q, rd_data_valid_d;
  logic [ADDR_W-1:0] rd_addr_eff;
  logic              wr_acc, rd_acc;

`ifdef JPEG_IDCT_RAM_TRANSPOSE_EN
  if (ADDR_W % 2 != 0) begin : g_addr_w_odd
    $error("jpeg_idct_pingpong_ram: ADDR_W must be even for transposed reads");
  end
  assign rd_addr_eff = {rd_addr_i[ADDR_W/2-1:0], rd_addr_i[ADDR_W-1:ADDR_W/2]};
`else
  assign rd_addr_eff = rd_addr_i;
`endif

  assign wr_ready_o      = ~full_q[wr_bank_q];
  assign rd_valid_o      = full_q[rd_bank_q];
  assign level_o         = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_data_valid_q;

  assign wr_acc = wr_i & wr_ready_o;
  assign rd_acc = rd_i & rd_valid_o;

  // Commit and release always target different banks, so both may apply in one cycle.
  always_comb begin
    full_d          = full_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = rd_acc;
    if (wr_acc && wr_last_i) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_acc) begin
      rd_data_d = mem[{rd_bank_q, rd_addr_eff}];
      if (rd_last_i) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      full_q          <= 2'b00;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      full_q          <= full_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[{wr_bank_q, wr_addr_i}] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_jpeg_idct_pingpong_ram.sv
// Bench for jpeg_idct_pingpong_ram: bank-ownership model checked every cycle plus directed literal checks.
module tb_jpeg_idct_pingpong_ram;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_i = 1'b0, wr_last_i = 1'b0, rd_i = 1'b0, rd_last_i = 1'b0;
  logic [ADDR_W-1:0] wr_addr_i = '0, rd_addr_i = '0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              wr_ready_o, rd_valid_o, rd_data_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [1:0]        level_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  jpeg_idct_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_i(wr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_last_i(wr_last_i),
    .wr_ready_o(wr_ready_o), .rd_valid_o(rd_valid_o),
    .rd_i(rd_i), .rd_addr_i(rd_addr_i), .rd_last_i(rd_last_i),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  function automatic int tr(input int a);
`ifdef JPEG_IDCT_RAM_TRANSPOSE_EN
    return ((a & 7) << 3) | (a >> 3);
`else
    return a;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: two physical banks, a queue of committed bank ids and a write-side bank pointer.
  logic [DATA_W-1:0] m_mem [2][64];
  int                m_committed[$];
  int                m_wb;
  logic [DATA_W-1:0] m_data;
  bit                m_dv;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_committed.delete();
      m_wb   = 0;
      m_data = '0;
      m_dv   = 1'b0;
    end else begin
      bit wr_ok, rd_ok;
      int rb;
      wr_ok = wr_i && (m_committed.size() < 2);
      rd_ok = rd_i && (m_committed.size() > 0);
      rb    = (m_committed.size() > 0) ? m_committed[0] : 0;
      m_dv  = rd_ok;
      if (rd_ok) m_data = m_mem[rb][tr(int'(rd_addr_i))];
      if (rd_ok && rd_last_i) void'(m_committed.pop_front());
      if (wr_ok) begin
        m_mem[m_wb][wr_addr_i] = wr_data_i;
        if (wr_last_i) begin
          m_committed.push_back(m_wb);
          m_wb = 1 - m_wb;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst_i) begin
      chk("model_wr_ready", wr_ready_o, m_committed.size() < 2);
      chk("model_rd_valid", rd_valid_o, m_committed.size() > 0);
      chk("model_level", level_o, m_committed.size());
      chk("model_rd_dv", rd_data_valid_o, m_dv);
      chk("model_rd_data", rd_data_o, m_data);
    end
  end

  task automatic cyc(input bit w, input int wa, input int wd, input bit wl,
                     input bit r, input int ra, input bit rl);
    wr_i = w; wr_addr_i = ADDR_W'(wa); wr_data_i = DATA_W'(wd); wr_last_i = wl;
    rd_i = r; rd_addr_i = ADDR_W'(ra); rd_last_i = rl;
    @(posedge clk); #1;
    wr_i = 1'b0; wr_last_i = 1'b0; rd_i = 1'b0; rd_last_i = 1'b0;
  endtask

  task automatic wr_block(input int base);
    for (int a = 0; a < 64; a++) cyc(1, a, base + a, a == 63, 0, 0, 0);
  endtask

  task automatic rd_block(input int base, input string nm);
    for (int a = 0; a < 64; a++) begin
      cyc(0, 0, 0, 0, 1, a, a == 63);
      chk(nm, rd_data_o, base + tr(a));
      chk("rd_dv_lat1", rd_data_valid_o, 1);
    end
  endtask

  initial begin
    #12;
    chk("rst_wr_ready", wr_ready_o, 1);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_dv", rd_data_valid_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk_en = 1'b1;

    // Single block, data = addr
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("rd_empty_ignored", rd_data_valid_o, 0);
    wr_block(0);
    chk("blk_rd_valid", rd_valid_o, 1);
    chk("blk_level", level_o, 1);
    rd_block(0, "blk_rd_data");
    chk("blk_drained_level", level_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idle_dv_low", rd_data_valid_o, 0);
    chk("idle_data_hold", rd_data_o, tr(63));

    // Two blocks committed, third write dropped
    wr_block(16'h1000);
    wr_block(16'h2000);
    chk("full_wr_ready", wr_ready_o, 0);
    chk("full_level", level_o, 2);
    cyc(1, 5, 16'hDEAD, 1, 0, 0, 0);
    chk("drop_level", level_o, 2);
    rd_block(16'h1000, "drain_a");
    chk("after_a_level", level_o, 1);
    rd_block(16'h2000, "drain_b");

    // Simultaneous commit and release
    wr_block(16'h3000);
    for (int a = 0; a < 63; a++) cyc(1, a, 16'h4000 + a, 0, 1, a, 0);
    cyc(1, 63, 16'h4000 + 63, 1, 1, 63, 1);
    chk("same_cyc_level", level_o, 1);
    chk("same_cyc_wr_ready", wr_ready_o, 1);
    chk("same_cyc_rd_valid", rd_valid_o, 1);
    chk("same_cyc_last_data", rd_data_o, 16'h3000 + tr(63));
    rd_block(16'h4000, "drain_d");

    // Reset mid-block
    wr_block(16'h5000);
    for (int a = 0; a < 30; a++) cyc(1, a, 16'h6000 + a, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_level", level_o, 0);
    chk("arst_rd_valid", rd_valid_o, 0);
    chk("arst_wr_ready", wr_ready_o, 1);
    chk("arst_rd_data", rd_data_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    wr_block(16'h7000);
    chk("post_rst_level", level_o, 1);
    rd_block(16'h7000, "post_rst_data");

    // Address mapping
    wr_block(0);
    cyc(0, 0, 0, 0, 1, 1, 0);
`ifdef JPEG_IDCT_RAM_TRANSPOSE_EN
    chk("map_addr1", rd_data_o, 8);
`else
    chk("map_addr1", rd_data_o, 1);
`endif
    cyc(0, 0, 0, 0, 1, 10, 0);
`ifdef JPEG_IDCT_RAM_TRANSPOSE_EN
    chk("map_addr10", rd_data_o, 17);
`else
    chk("map_addr10", rd_data_o, 10);
`endif
    cyc(0, 0, 0, 0, 1, 63, 1);
    chk("map_final_level", level_o, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
